// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter: round-robin read-side stage between four FWFT input FIFOs
// and four output FIFOs. Each cycle one eligible input is popped and its head
// word is pushed, one cycle later, into the output FIFO selected by the word's
// two class MSBs. Output FIFOs that are almost full block every input whose
// head word targets them.
module fifo_pop_arbiter #(
  parameter int WORD_SIZE = 10,
  parameter int NUM_FIFO  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FIFO-1:0]           fifo_empty,
  input  logic [NUM_FIFO*WORD_SIZE-1:0] data_in,
  input  logic [NUM_FIFO-1:0]           almost_full,
  output logic [NUM_FIFO-1:0]           pop,
  output logic [NUM_FIFO-1:0]           push,
  output logic [WORD_SIZE-1:0]          data_out,
  output logic                          stall,
  output logic [7:0]                    xfer_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    STALL  = 2'b10
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [1:0]           rr_ptr;
  logic [1:0]           dest [NUM_FIFO];
  logic [NUM_FIFO-1:0]  eligible;
  logic                 grant_valid;
  logic [1:0]           grant_idx;
  logic [1:0]           cand;
  logic [WORD_SIZE-1:0] grant_word;
  logic [NUM_FIFO-1:0]  push_q;

  // Destination class of each head word and whether it may be popped now.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_FIFO; i++) begin
      dest[i]     = data_in[i*WORD_SIZE + WORD_SIZE - 2 +: 2];
      eligible[i] = !fifo_empty[i] && !almost_full[dest[i]];
    end
  end

  // Round-robin search starting at rr_ptr; first eligible input wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned off = 0; off < NUM_FIFO; off++) begin
      cand = rr_ptr + off[1:0];
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_word = data_in[grant_idx*WORD_SIZE +: WORD_SIZE];

  // Mealy pop strobe, suppressed while reset is asserted.
  always_comb begin
    pop = '0;
    if (grant_valid && !reset)
      pop[grant_idx] = 1'b1;
  end

  // Transfer datapath: capture the granted word and strobe its destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      push_q     <= '0;
      data_out   <= '0;
      xfer_count <= '0;
    end else if (grant_valid) begin
      rr_ptr           <= grant_idx + 2'd1;
      push_q           <= '0;
      push_q[dest[grant_idx]] <= 1'b1;
      data_out         <= grant_word;
      xfer_count       <= xfer_count + 8'd1;
    end else begin
      push_q <= '0;
    end
  end

  // A word popped in the cycle before reset is dropped: masking the registered
  // strobe with reset keeps it from ever reaching the output FIFO.
  assign push = reset ? '0 : push_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next state from this cycle's input conditions.
  always_comb begin
    next_state = IDLE;
    if (fifo_empty == '1)
      next_state = IDLE;
    else if (grant_valid)
      next_state = ACTIVE;
    else
      next_state = STALL;
  end

  assign stall = (state == STALL);

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Directed self-checking bench for fifo_pop_arbiter.
module tb_fifo_pop_arbiter;

  localparam int WS = 10;
  localparam int NF = 4;

  logic             clk;
  logic             reset;
  logic [NF-1:0]    fifo_empty;
  logic [NF*WS-1:0] data_in;
  logic [NF-1:0]    almost_full;
  logic [NF-1:0]    pop;
  logic [NF-1:0]    push;
  logic [WS-1:0]    data_out;
  logic             stall;
  logic [7:0]       xfer_count;

  int n_assert;
  int n_fail;

  fifo_pop_arbiter #(.WORD_SIZE(WS), .NUM_FIFO(NF)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .data_in    (data_in),
    .almost_full(almost_full),
    .pop        (pop),
    .push       (push),
    .data_out   (data_out),
    .stall      (stall),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NF*WS-1:0] pack(input logic [WS-1:0] h0, input logic [WS-1:0] h1,
                                            input logic [WS-1:0] h2, input logic [WS-1:0] h3);
    return {h3, h2, h1, h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset held two cycles with every input non-empty.
    reset       = 1'b1;
    fifo_empty  = 4'b0000;
    data_in     = pack(10'h000, 10'h100, 10'h200, 10'h300);
    almost_full = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_pop",   32'(pop), 0);
      check("rst_push",  32'(push), 0);
      check("rst_data",  32'(data_out), 0);
      check("rst_count", 32'(xfer_count), 0);
      check("rst_stall", 32'(stall), 0);
    end

    // Round-robin: grant in the first cycle out of reset, then 1,2,3,0.
    reset = 1'b0;
    #1;
    check("rr_pop0", 32'(pop), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rr_push",  32'(push), 32'(1 << ((k - 1) % 4)));
      check("rr_data",  32'(data_out), 32'((k - 1) % 4) << 8);
      check("rr_count", 32'(xfer_count), 32'(k));
      check("rr_pop",   32'(pop), 32'(1 << (k % 4)));
      check("rr_stall", 32'(stall), 0);
    end

    // Routing: only input 2 holds data, class 3.
    fifo_empty = 4'b1011;
    data_in    = pack(10'h000, 10'h100, 10'h3A5, 10'h300);
    #1;
    check("route_pop", 32'(pop), 32'h4);
    tick();
    check("route_push",  32'(push), 32'h8);
    check("route_data",  32'(data_out), 32'h3A5);
    check("route_count", 32'(xfer_count), 5);

    // Bring rr_ptr to 0 by granting input 3 (rr_ptr currently 3).
    fifo_empty = 4'b0111;
    data_in    = pack(10'h000, 10'h100, 10'h200, 10'h300);
    #1;
    check("align_pop", 32'(pop), 32'h8);
    tick();
    check("align_push",  32'(push), 32'h8);
    check("align_count", 32'(xfer_count), 6);

    // Back-pressure skip: input 0 targets blocked class 1, input 1 class 0.
    fifo_empty  = 4'b1100;
    data_in     = pack(10'h1FF, 10'h011, 10'h200, 10'h300);
    almost_full = 4'b0010;
    #1;
    check("bp_pop", 32'(pop), 32'h2);
    tick();
    check("bp_push",  32'(push), 32'h1);
    check("bp_data",  32'(data_out), 32'h011);
    check("bp_count", 32'(xfer_count), 7);

    // Both destinations blocked: no grant, stall one cycle later.
    almost_full = 4'b0011;
    #1;
    check("blk_pop", 32'(pop), 0);
    check("blk_stall_early", 32'(stall), 0);
    tick();
    check("blk_push",  32'(push), 0);
    check("blk_data",  32'(data_out), 32'h011);
    check("blk_count", 32'(xfer_count), 7);
    check("blk_stall", 32'(stall), 1);
    check("blk_pop2",  32'(pop), 0);

    // Wrap: 249 more transfers take the count from 7 to 256 -> 0.
    fifo_empty  = 4'b0000;
    data_in     = pack(10'h000, 10'h100, 10'h200, 10'h300);
    almost_full = 4'b0000;
    for (int k = 0; k < 249; k++) tick();
    check("wrap_count0", 32'(xfer_count), 0);
    check("wrap_stall",  32'(stall), 0);
    for (int k = 0; k < 7; k++) tick();
    check("wrap_count7", 32'(xfer_count), 7);
    check("wrap_push_live", 32'(push != 4'b0000), 1);

    // Idle: empty all inputs.
    fifo_empty = 4'b1111;
    #1;
    check("idle_pop", 32'(pop), 0);
    tick();
    check("idle_push",  32'(push), 0);
    check("idle_stall", 32'(stall), 0);
    check("idle_state", 32'(dut.state), 0);
    check("idle_count", 32'(xfer_count), 7);

    // Mid-operation reset: pop input 0, then reset in the following cycle.
    fifo_empty = 4'b1110;
    #1;
    check("mid_pop", 32'(pop), 32'h1);
    tick();
    reset      = 1'b1;
    fifo_empty = 4'b0000;
    #1;
    check("mid_push_cancel", 32'(push), 0);
    check("mid_pop_forced",  32'(pop), 0);
    tick();
    check("mid_push", 32'(push), 0);
    check("mid_rr",   32'(dut.rr_ptr), 0);
    check("mid_count", 32'(xfer_count), 0);
    check("mid_data",  32'(data_out), 0);
    reset      = 1'b0;
    fifo_empty = 4'b1001;
    #1;
    check("post_pop", 32'(pop), 32'h2);
    tick();
    check("post_push",  32'(push), 32'h2);
    check("post_data",  32'(data_out), 32'h100);
    check("post_count", 32'(xfer_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Read-side stage placed directly downstream of four input FIFOs, each managed by the FIFO control logic. Every cycle it grants one of the non-empty FIFOs in round-robin order, pops its head word and routes it to one of four output FIFOs chosen by the word's two class bits. It respects each output FIFO's almost_full flag so that no write ever reaches a full memory, which keeps the downstream control logic's overflow `error` at 0.

## Interface
- `WORD_SIZE`, 10: bits per word. The two MSBs `[WORD_SIZE-1:WORD_SIZE-2]` are the destination class.
- `NUM_FIFO`, 4: number of input FIFOs and of output FIFOs. Fixed at 4; the class field is 2 bits wide.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `fifo_empty` in 4: per-input-FIFO empty flag.
- `data_in` in 4*WORD_SIZE: head words of the input FIFOs, which are first-word-fall-through. Input i occupies slice `[i*WORD_SIZE +: WORD_SIZE]` and is valid when `fifo_empty[i]`=0.
- `almost_full` in 4: per-output-FIFO almost-full flag. Its threshold must leave at least 1 free slot.
- `pop` out 4: one-hot read strobe to the input FIFOs. Combinational.
- `push` out 4: one-hot write strobe to the output FIFOs. Registered.
- `data_out` out WORD_SIZE: word written with `push`. Registered.
- `stall` out 1: high while data is pending but blocked.
- `xfer_count` out 8: count of words transferred.

## Operation
- **Destination:** dest(i) = `data_in[i]` bits `[WORD_SIZE-1:WORD_SIZE-2]`.
- **Eligibility:** input i is eligible when `fifo_empty[i]`=0 and `almost_full[dest(i)]`=0.
- **Grant:**
  - Search inputs in the order rr_ptr, rr_ptr+1, … (mod 4). The first eligible input i is granted.
  - `pop[i]`=1 in the same cycle. At most one `pop` bit is high.
  - At most one grant per cycle.
- **Pointer update:** on a grant, rr_ptr <= i+1 mod 4. Without a grant, rr_ptr holds.
- **Transfer:** on a grant, at the next edge:
  - `push[dest(i)]` <= 1, `data_out` <= `data_in[i]` (class bits included).
  - `xfer_count` <= `xfer_count`+1, wrapping 255→0.
- **No grant:** `push` <= 0 and `data_out` holds its last value.
- **FSM** (2-bit register, updated every edge from the current cycle's conditions):
  - IDLE: all `fifo_empty`=1.
  - ACTIVE: a grant occurred.
  - STALL: some `fifo_empty`=0 but no input is eligible.
  - Any state can move to any state. `stall` = (state==STALL).
- **Reset** (`reset`=1 at an edge):
  - rr_ptr=0, state=IDLE, `push`=0, `data_out`=0, `xfer_count`=0.
  - While `reset`=1, `pop` is forced to 0.
  - A grant decoded in the reset cycle is discarded: no pop and no push follow it.

## Timing
- `pop` is Mealy: it is decoded from the current flags and the registered rr_ptr. The input FIFO advances at the same edge that captures `data_out`.
- Latency from pop to push: 1 cycle. Throughput: 1 word/cycle.
- `stall` and the FSM state lag the condition by 1 cycle.
- **Back-pressure margin:** a push may land 1 cycle after `almost_full` rises. The output FIFO thresholds must tolerate this, so full_threshold ≤ MEM_SIZE-2.
- **Simultaneous events:**
  - Several inputs eligible: round-robin decides.
  - Several inputs target the same dest: still only one grant per cycle.
  - An input whose head dest is blocked is skipped and loses no data. Its head is retried when it next becomes eligible.
- **Reset mid-transfer:** if `reset` is asserted in the cycle after a pop, that pop's push is cancelled (`push`=0) and the word is dropped. This is accepted behaviour; the system resets the FIFOs together with this block.
- Out of reset, the first grant can happen in the first cycle with `reset`=0.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles with all inputs non-empty → `pop`=0, `push`=0, `data_out`=0, `xfer_count`=0, `stall`=0.
- **Round-robin:**
  - Stimulus: all 4 inputs always non-empty, heads 0x000, 0x100, 0x200, 0x300, all `almost_full`=0.
  - Response: `pop` = 0001, 0010, 0100, 1000, 0001 on successive cycles.
  - One cycle later: `push` = 0001, 0010, 0100, 1000 with matching `data_out`.
- **Routing:** only input 2 non-empty, head 0x3A5 → `pop`=0100, next cycle `push`=1000 and `data_out`=0x3A5.
- **Back-pressure skip:**
  - Stimulus: inputs 0 and 1 non-empty, heads 0x1FF and 0x011, rr_ptr=0, `almost_full`=0010.
  - Response: input 1 granted (dest 0), not input 0.
  - Then set `almost_full`=0011 → no grant, and `stall`=1 one cycle later.
- **Wrap and idle:**
  - Run 256 transfers → `xfer_count` returns to 0.
  - Empty all inputs → state IDLE, `push`=0 one cycle after the last pop.
- **Mid-operation reset:** pop from input 0, then `reset`=1 on the next cycle → `push` stays 0000, rr_ptr=0, and the first post-reset grant goes to the lowest eligible index.
